// File: rtl/grng_sample_collector.sv
// Consumer end of the Ziggurat GRNG pipeline: filters rejected samples, buffers accepted
// Q8.28 values in a FWFT FIFO, throttles Stage1 through hold, and keeps sample counters.
module grng_sample_collector #(
    parameter int unsigned WIDTH      = 36,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LOG2DEPTH  = 4,
    parameter int unsigned PIPE_DEPTH = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic                 reject_in,
    input  logic [WIDTH-1:0]     value_in,
    input  logic [CNT_W-1:0]     limit,
    output logic                 hold,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [LOG2DEPTH:0]   level,
    output logic [CNT_W-1:0]     total_count,
    output logic [CNT_W-1:0]     reject_count,
    output logic                 overflow,
    output logic                 done
);

    localparam logic [LOG2DEPTH:0] FULL_LVL = (LOG2DEPTH + 1)'(DEPTH);
    // Threshold leaves room for PIPE_DEPTH in-flight samples plus one cycle of gating delay.
    localparam logic [LOG2DEPTH:0] HOLD_LVL = (LOG2DEPTH + 1)'(DEPTH - PIPE_DEPTH - 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG2DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2DEPTH:0]   level_q, level_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic [CNT_W-1:0]     reject_q, reject_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;

    logic                 seen;
    logic                 push_req;
    logic                 pop;
    logic                 full;
    logic                 push;
    logic                 drop;
    logic [CNT_W-1:0]     total_inc;
    logic                 total_sat;
    logic                 reject_sat;

    always_comb begin
        seen       = valid_in && !done_q;
        push_req   = seen && !reject_in;
        pop        = (level_q != '0) && out_ready;
        full       = (level_q == FULL_LVL);
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        total_inc  = total_q + CNT_W'(1);
        total_sat  = &total_q;
        reject_sat = &reject_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        total_d    = total_q;
        reject_d   = reject_q;
        overflow_d = overflow_q;
        done_d     = done_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + LOG2DEPTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + LOG2DEPTH'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + (LOG2DEPTH + 1)'(1);
            2'b01:   level_d = level_q - (LOG2DEPTH + 1)'(1);
            default: level_d = level_q;
        endcase

        if (seen && !total_sat) begin
            total_d = total_inc;
        end
        if (seen && reject_in && !reject_sat) begin
            reject_d = reject_q + CNT_W'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        // Equality on the incrementing edge only; lowering limit later never sets done.
        if (seen && !total_sat && (limit != '0) && (total_inc == limit)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            total_q    <= '0;
            reject_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            total_q    <= total_d;
            reject_q   <= reject_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= value_in;
        end
    end

    assign out_valid    = (level_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign total_count  = total_q;
    assign reject_count = reject_q;
    assign overflow     = overflow_q;
    assign done         = done_q;
    assign hold         = done_q || (level_q >= HOLD_LVL);

endmodule

// File: tb/tb_grng_sample_collector.sv
// Self-checking bench for grng_sample_collector: vector table plus directed corner sequences,
// with a scoreboard queue checking every popped FIFO head.
module tb_grng_sample_collector;

    localparam int W  = 36;
    localparam int D  = 16;
    localparam int LD = 4;
    localparam int PD = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          reject_in;
    logic [W-1:0]  value_in;
    logic [CW-1:0] limit;
    logic          hold;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LD:0]   level;
    logic [CW-1:0] total_count;
    logic [CW-1:0] reject_count;
    logic          overflow;
    logic          done;

    grng_sample_collector #(
        .WIDTH      (W),
        .DEPTH      (D),
        .LOG2DEPTH  (LD),
        .PIPE_DEPTH (PD),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .reject_in    (reject_in),
        .value_in     (value_in),
        .limit        (limit),
        .hold         (hold),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .total_count  (total_count),
        .reject_count (reject_count),
        .overflow     (overflow),
        .done         (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic          v;
        logic          rej;
        logic [W-1:0]  val;
        logic          rdy;
        logic [LD:0]   lvl;
        logic          ov;
        logic [CW-1:0] tot;
        logic [CW-1:0] rjc;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input bit v, input bit rej, input int val, input bit rdy,
                                input int lvl, input bit ov, input int tot, input int rjc);
        vec_t m;
        m.v   = v;
        m.rej = rej;
        m.val = W'(val);
        m.rdy = rdy;
        m.lvl = (LD + 1)'(lvl);
        m.ov  = ov;
        m.tot = CW'(tot);
        m.rjc = CW'(rjc);
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a pop happens at the next posedge whenever head is valid and ready is high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got data %0h expected no output", out_data);
            end else begin
                check("pop_data", 64'(out_data), 64'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v, input logic rej, input bit accept);
        valid_in  = 1'b1;
        reject_in = rej;
        value_in  = v;
        if (accept) sb.push_back(v);
        tick();
    endtask

    task automatic idle();
        valid_in  = 1'b0;
        reject_in = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        valid_in  = 1'b0;
        reject_in = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        idle();
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got out_valid still 1 expected drained within 40 cycles", name);
        end
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_level0"}, 64'(level), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        reject_in = 1'b0;
        value_in  = '0;
        limit     = '0;
        out_ready = 1'b0;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_total", 64'(total_count), 64'd0);
        check("rst_reject", 64'(reject_count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hold", 64'(hold), 64'd0);
        rst = 1'b0;

        // Reject filtering: values 1..10, rejects on 3 and 7, ready held high.
        tbl[0]  = mk(1, 0, 1,  1, 1, 1, 1,  0);
        tbl[1]  = mk(1, 0, 2,  1, 1, 1, 2,  0);
        tbl[2]  = mk(1, 1, 3,  1, 0, 0, 3,  1);
        tbl[3]  = mk(1, 0, 4,  1, 1, 1, 4,  1);
        tbl[4]  = mk(1, 0, 5,  1, 1, 1, 5,  1);
        tbl[5]  = mk(1, 0, 6,  1, 1, 1, 6,  1);
        tbl[6]  = mk(1, 1, 7,  1, 0, 0, 7,  2);
        tbl[7]  = mk(1, 0, 8,  1, 1, 1, 8,  2);
        tbl[8]  = mk(1, 0, 9,  1, 1, 1, 9,  2);
        tbl[9]  = mk(1, 0, 10, 1, 1, 1, 10, 2);
        tbl[10] = mk(0, 0, 0,  1, 0, 0, 10, 2);
        for (int i = 0; i < 11; i++) begin
            valid_in  = tbl[i].v;
            reject_in = tbl[i].rej;
            value_in  = tbl[i].val;
            out_ready = tbl[i].rdy;
            if (tbl[i].v && !tbl[i].rej) sb.push_back(tbl[i].val);
            tick();
            check($sformatf("vec%0d_level", i), 64'(level), 64'(tbl[i].lvl));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            check($sformatf("vec%0d_total", i), 64'(total_count), 64'(tbl[i].tot));
            check($sformatf("vec%0d_reject", i), 64'(reject_count), 64'(tbl[i].rjc));
        end
        idle();
        check("vec_sb_empty", 64'(sb.size()), 64'd0);

        // Fill and hold: hold must rise once level reaches 10, then 5 in-flight samples land.
        do_reset();
        for (int i = 1; i <= 20 && !hold; i++) begin
            push(W'(100 + i), 1'b0, 1'b1);
        end
        check("fill_hold_level", 64'(level), 64'd10);
        check("fill_hold", 64'(hold), 64'd1);
        for (int i = 0; i < 5; i++) begin
            push(W'(200 + i), 1'b0, 1'b1);
        end
        idle();
        check("fill_level15", 64'(level), 64'd15);
        check("fill_overflow", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            tick();
            check($sformatf("fill_drain%0d_level", j), 64'(level), 64'(15 - j));
            check($sformatf("fill_drain%0d_hold", j), 64'(hold), 64'((15 - j) >= 10));
        end
        out_ready = 1'b0;
        check("fill_sb_empty", 64'(sb.size()), 64'd0);

        // Overflow: 18 pushes into a 16-entry FIFO with hold ignored.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            push(W'(300 + i), 1'b0, i < 16);
        end
        idle();
        check("ovf_level", 64'(level), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_total", 64'(total_count), 64'd18);
        drain("ovf");
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push(W'(400 + i), 1'b0, 1'b1);
        end
        check("fpp_level_before", 64'(level), 64'd16);
        out_ready = 1'b1;
        push(W'(36'h5A5A5A5A5), 1'b0, 1'b1);
        idle();
        out_ready = 1'b0;
        check("fpp_level_after", 64'(level), 64'd16);
        check("fpp_overflow", 64'(overflow), 64'd0);
        drain("fpp");

        // Limit: lowering below the count must not set done; equality does.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(W'(500 + i), 1'b0, 1'b1);
        end
        limit = 32'd2;
        push(W'(503), 1'b0, 1'b1);
        check("lim_lowered_done", 64'(done), 64'd0);
        check("lim_lowered_total", 64'(total_count), 64'd4);
        limit = 32'd5;
        push(W'(504), 1'b0, 1'b1);
        check("lim_done", 64'(done), 64'd1);
        check("lim_hold", 64'(hold), 64'd1);
        push(W'(505), 1'b0, 1'b0);
        push(W'(506), 1'b1, 1'b0);
        idle();
        check("lim_total_frozen", 64'(total_count), 64'd5);
        check("lim_reject_frozen", 64'(reject_count), 64'd0);
        check("lim_level", 64'(level), 64'd5);
        drain("lim");
        check("lim_done_sticky", 64'(done), 64'd1);
        check("lim_hold_after_drain", 64'(hold), 64'd1);
        limit = '0;

        // Mid-run reset with a sample presented during the reset cycle.
        do_reset();
        check("mrr_done_cleared", 64'(done), 64'd0);
        for (int i = 0; i < 6; i++) begin
            push(W'(600 + i), (i == 2), (i != 2));
        end
        idle();
        check("mrr_level6_pre", 64'(level), 64'd5);
        push(W'(606), 1'b0, 1'b1);
        idle();
        check("mrr_level6", 64'(level), 64'd6);
        rst       = 1'b1;
        valid_in  = 1'b1;
        value_in  = W'(36'hDEAD);
        sb.delete();
        tick();
        rst = 1'b0;
        idle();
        check("mrr_out_valid", 64'(out_valid), 64'd0);
        check("mrr_level", 64'(level), 64'd0);
        check("mrr_total", 64'(total_count), 64'd0);
        check("mrr_reject", 64'(reject_count), 64'd0);
        check("mrr_overflow", 64'(overflow), 64'd0);
        check("mrr_done", 64'(done), 64'd0);
        check("mrr_hold", 64'(hold), 64'd0);
        out_ready = 1'b1;
        push(W'(700), 1'b0, 1'b1);
        push(W'(701), 1'b0, 1'b1);
        drain("mrr");
        check("mrr_total_resume", 64'(total_count), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
